// File: rtl/reward_calc_pipe.sv
// reward_calc_pipe
//   Turns a stream of state-index samples into a per-step reward. The first
//   sample of an episode only arms the block; every later valid sample is
//   compared against the held previous sample and yields one reward, one
//   cycle later.
//     mode 0 : R_UP / R_EQ / R_DN depending on S_in vs S_prev
//     mode 1 : (S_in - S_prev) * R_STEP
//   The integer reward is scaled by 2^FRAC and saturated into a RW-bit
//   Q(RW-FRAC).FRAC two's-complement result.
//
// Ports
//   CLK         rising-edge clock
//   RST         asynchronous active-low reset
//   S_in        current state index, sampled when S_valid=1
//   S_valid     S_in (and mode) valid this cycle
//   ep_start    episode start: drop the held previous state
//   mode        reward rule for this sample (0 ternary, 1 delta-scaled)
//   rewardOut   last reward (holds between pulses)
//   rewardValid one-cycle pulse: rewardOut is new
//   accOut      saturating episode reward sum      (REWARD_ACC_EN only)
//   stepCnt     saturating episode reward count    (REWARD_ACC_EN only)
//
// Optional feature: define REWARD_ACC_EN to build the episode accumulator.
`timescale 1ns/1ps

module reward_calc_pipe #(
  parameter int unsigned SW     = 3,
  parameter int unsigned RW     = 14,
  parameter int unsigned FRAC   = 9,
  parameter int          R_UP   = 6,
  parameter int          R_EQ   = 2,
  parameter int          R_DN   = -2,
  parameter int          R_STEP = 2,
  parameter int unsigned CW     = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [SW-1:0] S_in,
  input  logic          S_valid,
  input  logic          ep_start,
  input  logic          mode,
  output logic [RW-1:0] rewardOut,
  output logic          rewardValid
`ifdef REWARD_ACC_EN
  ,
  output logic [RW-1:0] accOut,
  output logic [CW-1:0] stepCnt
`endif
);

  // Wide enough for (delta * R_STEP) << FRAC and for acc + reward without wrap.
  localparam int unsigned IW = SW + FRAC + 36;

  localparam logic signed [IW-1:0] ONE_W = 1;
  localparam logic signed [IW-1:0] MAX_W = (ONE_W <<< (RW - 1)) - ONE_W;
  localparam logic signed [IW-1:0] MIN_W = -(ONE_W <<< (RW - 1));

  typedef enum logic {
    IDLE,
    ARMED
  } state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       s_prev_q, s_prev_d;
  logic [RW-1:0]       reward_q, reward_d;
  logic                valid_q, valid_d;

  logic signed [SW:0]    delta;
  logic signed [IW-1:0]  raw_w;
  logic signed [IW-1:0]  scaled_w;

  function automatic logic [RW-1:0] sat(input logic signed [IW-1:0] v);
    if (v > MAX_W)      return MAX_W[RW-1:0];
    else if (v < MIN_W) return MIN_W[RW-1:0];
    else                return v[RW-1:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    s_prev_d = s_prev_q;
    reward_d = reward_q;
    valid_d  = 1'b0;

    delta = $signed({1'b0, S_in}) - $signed({1'b0, s_prev_q});
    if (mode)                 raw_w = IW'(delta) * IW'(R_STEP);
    else if (S_in > s_prev_q) raw_w = IW'(R_UP);
    else if (S_in == s_prev_q) raw_w = IW'(R_EQ);
    else                      raw_w = IW'(R_DN);
    scaled_w = raw_w <<< FRAC;

    if (S_valid) begin
      s_prev_d = S_in;
      // ep_start with a valid sample restarts the episode on that sample.
      if (ep_start || state_q == IDLE) begin
        state_d = ARMED;
      end else begin
        valid_d  = 1'b1;
        reward_d = sat(scaled_w);
      end
    end else if (ep_start) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      s_prev_q <= '0;
      reward_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_prev_q <= s_prev_d;
      reward_q <= reward_d;
      valid_q  <= valid_d;
    end
  end

  assign rewardOut   = reward_q;
  assign rewardValid = valid_q;

`ifdef REWARD_ACC_EN
  logic [RW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        step_cnt_q, step_cnt_d;
  logic signed [IW-1:0] acc_sum_w;

  always_comb begin
    acc_d      = acc_q;
    step_cnt_d = step_cnt_q;
    acc_sum_w  = IW'($signed(acc_q)) + IW'($signed(reward_d));
    if (ep_start) begin
      acc_d      = '0;
      step_cnt_d = '0;
    end else if (valid_d) begin
      acc_d = sat(acc_sum_w);
      if (step_cnt_q != '1) step_cnt_d = step_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q      <= '0;
      step_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign accOut  = acc_q;
  assign stepCnt = step_cnt_q;
`endif

endmodule

// File: tb/tb_reward_calc_pipe.sv
// Bench for reward_calc_pipe: directed vector table, reset/episode corner
// sequences, then randomized traffic against an arithmetic reference model.
// Two instances run in lockstep: defaults (R_STEP=2) and R_STEP=3.
`timescale 1ns/1ps

module tb_reward_calc_pipe;

  logic        CLK;
  logic        RST;
  logic [2:0]  S_in;
  logic        S_valid;
  logic        ep_start;
  logic        mode;
  logic [13:0] r1_out, r2_out;
  logic        r1_v, r2_v;
`ifdef REWARD_ACC_EN
  logic [13:0] acc1, acc2;
  logic [7:0]  cnt1, cnt2;
`endif

  reward_calc_pipe dut1 (
    .CLK(CLK), .RST(RST), .S_in(S_in), .S_valid(S_valid),
    .ep_start(ep_start), .mode(mode),
    .rewardOut(r1_out), .rewardValid(r1_v)
`ifdef REWARD_ACC_EN
    , .accOut(acc1), .stepCnt(cnt1)
`endif
  );

  reward_calc_pipe #(.R_STEP(3)) dut2 (
    .CLK(CLK), .RST(RST), .S_in(S_in), .S_valid(S_valid),
    .ep_start(ep_start), .mode(mode),
    .rewardOut(r2_out), .rewardValid(r2_v)
`ifdef REWARD_ACC_EN
    , .accOut(acc2), .stepCnt(cnt2)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle past the edge.
  task automatic step(input logic v, input logic [2:0] s, input logic m, input logic ep);
    S_valid  = v;
    S_in     = s;
    mode     = m;
    ep_start = ep;
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  s;
    logic        m;
    logic        ep;
    logic        exp_v;
    logic [13:0] exp1;
    logic [13:0] exp2;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [2:0] s, input logic m,
                              input logic ep, input logic ev,
                              input logic [13:0] e1, input logic [13:0] e2);
    vec_t t;
    t.v = v; t.s = s; t.m = m; t.ep = ep; t.exp_v = ev; t.exp1 = e1; t.exp2 = e2;
    return t;
  endfunction

  // Reference: integer reward from the rules, scaled by 512, clamped to 14 bits.
  function automatic logic [13:0] model_reward(input int m, input int s, input int p, input int rstep);
    int r;
    if (m == 0) r = (s > p) ? 6 : ((s == p) ? 2 : -2);
    else        r = (s - p) * rstep;
    r = r * 512;
    if (r > 8191)  r = 8191;
    if (r < -8192) r = -8192;
    return r[13:0];
  endfunction

  vec_t tbl[14];

  initial begin
    RST = 1'b0; S_in = '0; S_valid = 1'b0; ep_start = 1'b0; mode = 1'b0;
    #3;
    chk("reset_out1", 32'(r1_out), 32'h0);
    chk("reset_v1",   32'(r1_v),   32'h0);
    chk("reset_out2", 32'(r2_out), 32'h0);
`ifdef REWARD_ACC_EN
    chk("reset_acc", 32'(acc1), 32'h0);
    chk("reset_cnt", 32'(cnt1), 32'h0);
`endif
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;

    //            v     s     m     ep    ev    dut1      dut2 (R_STEP=3)
    tbl[0]  = mk(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000);
    tbl[1]  = mk(1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 14'h0C00, 14'h0C00);
    tbl[2]  = mk(1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 14'h0C00, 14'h0C00);
    tbl[3]  = mk(1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 14'h0400, 14'h0400);
    tbl[4]  = mk(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 14'h3C00, 14'h3C00);
    tbl[5]  = mk(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 14'h3800, 14'h3400);
    tbl[6]  = mk(1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 14'h1C00, 14'h1FFF);
    tbl[7]  = mk(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 14'h2400, 14'h2000);
    tbl[8]  = mk(1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 14'h0C00, 14'h0C00);
    tbl[9]  = mk(1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 14'h0C00, 14'h0C00);
    tbl[10] = mk(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 14'h0C00, 14'h0C00);
    tbl[11] = mk(1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 14'h0C00, 14'h0C00);
    tbl[12] = mk(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 14'h0C00, 14'h0C00);
    tbl[13] = mk(1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 14'h0400, 14'h0400);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].m, tbl[i].ep);
      chk($sformatf("tbl%0d_v1", i),   32'(r1_v),   32'(tbl[i].exp_v));
      chk($sformatf("tbl%0d_out1", i), 32'(r1_out), 32'(tbl[i].exp1));
      chk($sformatf("tbl%0d_v2", i),   32'(r2_v),   32'(tbl[i].exp_v));
      chk($sformatf("tbl%0d_out2", i), 32'(r2_out), 32'(tbl[i].exp2));
    end

    // Asynchronous reset between edges while a reward pulse is showing.
    step(1'b1, 3'd7, 1'b0, 1'b0);
    chk("pre_rst_v",   32'(r1_v),   32'h1);
    chk("pre_rst_out", 32'(r1_out), 32'h0C00);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_out1", 32'(r1_out), 32'h0);
    chk("async_rst_v1",   32'(r1_v),   32'h0);
    chk("async_rst_out2", 32'(r2_out), 32'h0);
    #2;
    RST = 1'b1;
    step(1'b1, 3'd5, 1'b0, 1'b0);
    chk("post_rst_first_v", 32'(r1_v), 32'h0);
    step(1'b1, 3'd5, 1'b0, 1'b0);
    chk("post_rst_second_v",   32'(r1_v),   32'h1);
    chk("post_rst_second_out", 32'(r1_out), 32'h0400);

`ifdef REWARD_ACC_EN
    step(1'b1, 3'd0, 1'b0, 1'b1);
    chk("acc_clear_on_ep", 32'(acc1), 32'h0);
    step(1'b1, 3'd1, 1'b0, 1'b0);
    chk("acc_after_1", 32'(acc1), 32'h0C00);
    chk("cnt_after_1", 32'(cnt1), 32'h1);
    step(1'b1, 3'd2, 1'b0, 1'b0);
    step(1'b1, 3'd3, 1'b0, 1'b0);
    chk("acc_sat", 32'(acc1), 32'h1FFF);
    chk("cnt_3",   32'(cnt1), 32'h3);
    step(1'b0, 3'd3, 1'b0, 1'b1);
    chk("acc_ep_zero", 32'(acc1), 32'h0);
    chk("cnt_ep_zero", 32'(cnt1), 32'h0);
`endif

    // Randomized traffic from a clean reset against the reference model.
    begin
      bit          have_prev;
      int          prev;
      logic [13:0] e1, e2;
      logic        ev;
      int          acc, cnt;
      logic        v, m, ep;
      logic [2:0]  s;

      S_valid = 1'b0; ep_start = 1'b0;
      RST = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      have_prev = 1'b0; prev = 0; e1 = '0; e2 = '0; acc = 0; cnt = 0;

      for (int c = 0; c < 400; c++) begin
        v  = ($urandom_range(0, 3) != 0);
        ep = ($urandom_range(0, 9) == 0);
        m  = 1'($urandom_range(0, 1));
        s  = 3'($urandom_range(0, 7));
        ev = 1'b0;
        if (v) begin
          if (ep || !have_prev) begin
            have_prev = 1'b1;
          end else begin
            ev = 1'b1;
            e1 = model_reward(int'(m), int'(s), prev, 2);
            e2 = model_reward(int'(m), int'(s), prev, 3);
          end
          prev = int'(s);
        end else if (ep) begin
          have_prev = 1'b0;
        end
        if (ep) begin
          acc = 0; cnt = 0;
        end else if (ev) begin
          acc = acc + int'($signed(e1));
          if (acc > 8191)  acc = 8191;
          if (acc < -8192) acc = -8192;
          if (cnt < 255) cnt = cnt + 1;
        end

        step(v, s, m, ep);
        chk("rnd_v1",   32'(r1_v),   32'(ev));
        chk("rnd_out1", 32'(r1_out), 32'(e1));
        chk("rnd_v2",   32'(r2_v),   32'(ev));
        chk("rnd_out2", 32'(r2_out), 32'(e2));
`ifdef REWARD_ACC_EN
        chk("rnd_acc", 32'(acc1), 32'(acc[13:0]));
        chk("rnd_cnt", 32'(cnt1), 32'(cnt));
`endif
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reward_calc_pipe.md
REWARD_CALC_PIPE -- requirements
Module: reward_calc_pipe

Interface
REQ-001 SHALL provide parameter SW, 3, state-index width in bits (unsigned).
REQ-002 SHALL provide parameter RW, 14, reward width in bits (two's complement).
REQ-003 SHALL provide parameter FRAC, 9, fractional bits of the reward format.
REQ-004 SHALL provide parameters R_UP, 6; R_EQ, 2; R_DN, -2; these are the signed integer rewards used in mode 0.
REQ-005 SHALL provide parameter R_STEP, 2, signed integer reward per unit of state delta in mode 1.
REQ-006 SHALL provide parameter CW, 8, step-counter width.
REQ-007 CLK  input  1  single clock; all state updates occur on its rising edge.
REQ-008 RST  input  1  reset, asynchronous, active-low.
REQ-009 S_in  input  SW  current state index, sampled when S_valid=1.
REQ-010 S_valid  input  1  S_in is valid this cycle.
REQ-011 ep_start  input  1  episode start; discards the held previous state.
REQ-012 mode  input  1  0 = ternary compare, 1 = delta-scaled; sampled with S_valid.
REQ-013 rewardOut  output  RW  reward, Q(RW-FRAC).FRAC two's complement.
REQ-014 rewardValid  output  1  one-cycle pulse; rewardOut is new this cycle.
REQ-015 accOut  output  RW  saturating episode reward sum (present only with the macro).
REQ-016 stepCnt  output  CW  saturating count of rewards in the episode (present only with the macro).

Function
REQ-017 SHALL implement a two-state FSM: IDLE (no previous state held) and ARMED (S_prev held).
REQ-018 In IDLE with S_valid=1: SHALL capture S_prev<=S_in, go to ARMED, and produce no rewardValid.
REQ-019 In ARMED with S_valid=1: SHALL compute the reward from S_in vs S_prev, update S_prev<=S_in, and assert rewardValid on the next cycle (latency 1).
REQ-020 Mode 0: S_in>S_prev gives R_UP, S_in==S_prev gives R_EQ, S_in<S_prev gives R_DN; each is shifted left by FRAC.
REQ-021 Mode 1: delta = S_in-S_prev as a signed SW+1-bit value; the reward is (delta*R_STEP)<<FRAC.
REQ-022 All results SHALL saturate to [-2^(RW-1), 2^(RW-1)-1] using full-width intermediate arithmetic, never wrapping.
REQ-023 With S_valid=0: rewardValid=0, rewardOut holds its value, S_prev and FSM state are unchanged.
REQ-024 ep_start=1 SHALL force IDLE; if S_valid=1 in the same cycle, the sample is taken as the first of the new episode (captured, ARMED, no reward).
REQ-025 mode SHALL be allowed to change between any two samples; each reward uses the mode sampled with its S_in.

Reset
REQ-026 RST low SHALL asynchronously force IDLE, S_prev=0, rewardOut=0, rewardValid=0, accOut=0, stepCnt=0, regardless of any operation in progress.
REQ-027 After RST deasserts, the first valid sample SHALL be treated as in REQ-018.

Configuration
REQ-028 Macro REWARD_ACC_EN defined: accOut and stepCnt exist; each rewarded sample adds to accOut with saturation and increments stepCnt, which saturates at all-ones; both update in the same cycle as rewardValid.
REQ-029 With REWARD_ACC_EN defined, ep_start SHALL clear accOut and stepCnt to 0 on the next edge.
REQ-030 Macro REWARD_ACC_EN undefined: the accOut and stepCnt ports and their logic are absent; all other behaviour is identical.

Verification (defaults unless stated)
REQ-031 Reset, then S=3 valid, then S=5 valid (mode 0): no pulse for the first sample; 1 cycle after the second, rewardOut=0x0C00 and rewardValid=1 for exactly one cycle.
REQ-032 S=5 then 5 gives 0x0400; S=5 then 2 gives 0x3C00 (-1024).
REQ-033 Mode 1, S=0 then 7 gives 0x1C00; 7 then 0 gives 0x2400; with R_STEP=3, 0 then 7 gives 0x1FFF (saturated).
REQ-034 Sequence S=6, then ep_start with S=1, then S=2: no reward for S=1; the S=2 reward is 0x0C00 (compared against 1, not 6).
REQ-035 With REWARD_ACC_EN, samples 0,1,2,3 (mode 0): accOut=0x1FFF (18*512 saturated), stepCnt=3; after ep_start, both read 0.
REQ-036 RST pulled low mid-stream between clock edges: outputs read 0 immediately; the next valid sample yields no reward.
